ads_scan_sequencer: RTL and testbench
=====================================

// Module: ads_scan_sequencer
// PURPOSE
//  Sequences the ADC's 16-bit SPI frame engine: on each start, writes every channel's input-range
//  register, then scans enabled channels round-robin with manual-channel-select commands.
//  Handles the ADC's one-frame pipeline: each frame returns the conversion commanded by the previous
//  frame. Emits tagged samples. Sits between the frame engine (owns CS/SCLK/SDO/SDI) and capture logic.
// PARAMETERS
//  NUM_CH     4     channels sequenced, 1..8; channel index width CH_W = 3
//  RANGE_CODE 8'h06 range code written to every channel (0..1.25xVREF)
//  SCAN_GAP   8     idle cycles after frame_done before next frame_req, 0..255
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  run          in   1   level; high = configure then scan, low = stop after current frame
//  ch_mask      in   8   channel enables, bit i = channel i; bits >= NUM_CH ignored
//  frame_req    out  1   frame request to SPI engine
//  frame_cmd    out  16  command word for requested frame, MSB first on SDO
//  frame_ack    in   1   1-cycle pulse: engine accepted frame_cmd
//  frame_done   in   1   1-cycle pulse: frame finished, frame_rdata valid this cycle
//  frame_rdata  in   16  data shifted in during the frame
//  smp_valid    out  1   1-cycle pulse: new sample
//  smp_ch       out  3   channel of smp_data
//  smp_data     out  16  conversion result
//  cfg_done     out  1   high once range writes complete; cleared on IDLE entry
//  busy         out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; prime flag set. rst mid-frame aborts at once: frame_req low
//   next cycle; engine shares rst.
//  States: IDLE -> CFG_REQ -> CFG_WAIT -> (x NUM_CH) -> SEL -> SCAN_REQ -> SCAN_WAIT -> GAP -> SEL ...
//  IDLE: run=1 -> CFG_REQ, cfg index=0, cfg_done=0, prime=1.
//  CFG_REQ: frame_cmd={7'h05+idx,1'b1,RANGE_CODE}; frame_req=1 held, cmd stable until frame_ack;
//   ack -> CFG_WAIT, frame_req=0 same cycle as ack is seen (deasserts next edge).
//  CFG_WAIT: frame_done -> idx+1; idx==NUM_CH-1 -> cfg_done=1, SEL; else CFG_REQ. rdata ignored.
//  SEL: choose next enabled channel after last commanded (wraps NUM_CH-1 -> 0; first = lowest
//   enabled). ch_mask sampled here each frame. No enabled bit -> stay in SEL. run=0 -> IDLE.
//  SCAN_REQ: frame_cmd=16'hC000|(ch<<10) (ch0 C000, ch1 C400, ch7 DC00); same handshake as CFG_REQ.
//  SCAN_WAIT: on frame_done: prime=1 -> discard rdata, clear prime; else smp_valid=1 next cycle with
//   smp_data=frame_rdata, smp_ch=channel commanded by previous scan frame. Then GAP.
//  GAP: count SCAN_GAP cycles (0 -> leave next cycle); then run=1 -> SEL, run=0 -> IDLE.
//  run deasserted while a frame is outstanding: frame completes and its sample is emitted; no new req.
//  Restart from IDLE always repeats full configuration and priming.
//  frame_ack while frame_req=0, or frame_done outside *_WAIT: ignored.
//  smp_ch/smp_data hold last value between pulses. Latency frame_done -> smp_valid: 1 cycle.
// CONFIGURATION
//  ADS_SCAN_TIMESTAMP_EN defined: adds output smp_ts[31:0]; 32-bit free-running cycle counter,
//   0 at reset, wraps; value at the frame_done cycle is registered with smp_valid.
//  Undefined: no smp_ts port, no counter.
// TESTING
//  T1 rst, run=1, ch_mask=8'h0F, NUM_CH=4 -> cmds 0x0B06,0x0D06,0x0F06,0x1106, cfg_done=1, then
//     C000,C400,C800,CC00,C000; 1st scan rdata dropped; 2nd done rdata=0x1234 -> smp_ch=0,smp_data=0x1234.
//  T2 ch_mask=8'h05 -> cmds C000,C800,C000...; smp_ch sequence 0,2,0; mask->8'h00 mid-scan -> no req.
//  T3 engine delays frame_ack 10 cycles -> frame_req and frame_cmd stable all 10 cycles, one frame.
//  T4 run=0 during SCAN_WAIT -> that sample emitted, busy=0 after GAP, no req; run=1 -> 0x0B06 again.
//  T5 rst during SCAN_WAIT -> next cycle frame_req=0, busy=0, cfg_done=0, smp_valid=0.
//  T6 ADS_SCAN_TIMESTAMP_EN, SCAN_GAP=0 -> smp_ts of consecutive samples differ by exact frame period.

Source files
------------

// File: rtl/ads_scan_sequencer.sv
// ads_scan_sequencer
// Drives the ADC's 16-bit SPI frame engine. When run rises it writes every
// channel's input-range register. It then scans the enabled channels
// round-robin using manual-channel-select commands. The ADC returns each
// conversion one frame late, so the first scan frame after a start only
// primes the pipeline. Each later frame yields a sample tagged with the
// channel commanded in the previous scan frame.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   run          level: high = configure then scan, low = stop after current frame
//   ch_mask      channel enables (bits >= NUM_CH ignored), sampled in SEL
//   frame_req    request to SPI engine, held until frame_ack
//   frame_cmd    command word for the requested frame
//   frame_ack    engine accepted frame_cmd (1-cycle pulse)
//   frame_done   frame finished, frame_rdata valid (1-cycle pulse)
//   frame_rdata  data shifted in during the frame
//   smp_valid    1-cycle pulse, new sample on smp_ch / smp_data
//   cfg_done     range writes complete; cleared on return to IDLE
//   busy         high in any state except IDLE
//   smp_ts       (ADS_SCAN_TIMESTAMP_EN only) cycle count at the frame_done cycle
//
// Optional feature macro: ADS_SCAN_TIMESTAMP_EN

module ads_scan_sequencer #(
    parameter int         NUM_CH     = 4,
    parameter logic [7:0] RANGE_CODE = 8'h06,
    parameter int         SCAN_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  ch_mask,
    output logic        frame_req,
    output logic [15:0] frame_cmd,
    input  logic        frame_ack,
    input  logic        frame_done,
    input  logic [15:0] frame_rdata,
    output logic        smp_valid,
    output logic [2:0]  smp_ch,
    output logic [15:0] smp_data,
    output logic        cfg_done,
    output logic        busy
`ifdef ADS_SCAN_TIMESTAMP_EN
    ,
    output logic [31:0] smp_ts
`endif
);

    localparam int CH_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CFG_REQ,
        CFG_WAIT,
        SEL,
        SCAN_REQ,
        SCAN_WAIT,
        GAP
    } state_t;

    state_t          state, next_state;
    logic [CH_W-1:0] cfg_idx;
    logic [CH_W-1:0] last_ch;
    logic [CH_W-1:0] cur_ch;
    logic [CH_W-1:0] prev_ch;
    logic            prime;
    logic [7:0]      gap_cnt;

    logic            sel_found;
    logic [CH_W-1:0] sel_ch;
    logic [3:0]      scan_sum;
    logic            cfg_last;
    logic            gap_last;
    logic [8:0]      gap_next;

    assign cfg_last = (cfg_idx == CH_W'(NUM_CH - 1));
    assign gap_next = {1'b0, gap_cnt} + 9'd1;
    // GAP always lasts at least one cycle, so SCAN_GAP=0 leaves on the next cycle
    assign gap_last = (gap_next >= 9'(SCAN_GAP));
    assign busy     = (state != IDLE);

    // Round-robin search starting just after the last commanded channel.
    // Descending k lets the nearest enabled channel overwrite farther ones.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        scan_sum  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            scan_sum = {1'b0, last_ch} + 4'(k);
            if (scan_sum >= 4'(NUM_CH)) begin
                scan_sum = scan_sum - 4'(NUM_CH);
            end
            if (ch_mask[scan_sum[2:0]]) begin
                sel_found = 1'b1;
                sel_ch    = scan_sum[2:0];
            end
        end
    end

    always_comb begin
        next_state = state;
        frame_req  = 1'b0;
        frame_cmd  = 16'h0000;
        case (state)
            IDLE: begin
                if (run) next_state = CFG_REQ;
            end
            CFG_REQ: begin
                frame_req = 1'b1;
                frame_cmd = {7'h05 + {4'b0000, cfg_idx}, 1'b1, RANGE_CODE};
                if (frame_ack) next_state = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (frame_done) begin
                    if (!run)          next_state = IDLE;
                    else if (cfg_last) next_state = SEL;
                    else               next_state = CFG_REQ;
                end
            end
            SEL: begin
                if (!run)           next_state = IDLE;
                else if (sel_found) next_state = SCAN_REQ;
            end
            SCAN_REQ: begin
                frame_req = 1'b1;
                frame_cmd = 16'hC000 | ({13'd0, cur_ch} << 10);
                if (frame_ack) next_state = SCAN_WAIT;
            end
            SCAN_WAIT: begin
                if (frame_done) next_state = GAP;
            end
            GAP: begin
                if (gap_last) next_state = run ? SEL : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_idx   <= '0;
            last_ch   <= '0;
            cur_ch    <= '0;
            prev_ch   <= '0;
            prime     <= 1'b1;
            gap_cnt   <= '0;
            cfg_done  <= 1'b0;
            smp_valid <= 1'b0;
            smp_ch    <= '0;
            smp_data  <= '0;
        end else begin
            state     <= next_state;
            smp_valid <= 1'b0;
            if (state != IDLE && next_state == IDLE) begin
                cfg_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (run) begin
                        cfg_idx  <= '0;
                        cfg_done <= 1'b0;
                        prime    <= 1'b1;
                        // Start the search from the top so the first pick wraps to the lowest enabled channel
                        last_ch  <= CH_W'(NUM_CH - 1);
                    end
                end
                CFG_WAIT: begin
                    if (frame_done) begin
                        cfg_idx <= cfg_idx + 1'b1;
                        if (cfg_last && run) cfg_done <= 1'b1;
                    end
                end
                SEL: begin
                    if (run && sel_found) begin
                        cur_ch  <= sel_ch;
                        last_ch <= sel_ch;
                    end
                end
                SCAN_WAIT: begin
                    if (frame_done) begin
                        // The data in this frame belongs to the previous scan frame's channel
                        if (prime) begin
                            prime <= 1'b0;
                        end else begin
                            smp_valid <= 1'b1;
                            smp_data  <= frame_rdata;
                            smp_ch    <= prev_ch;
                        end
                        prev_ch <= cur_ch;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ADS_SCAN_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            smp_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == SCAN_WAIT && frame_done && !prime) begin
                smp_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ads_scan_sequencer.sv
// tb_ads_scan_sequencer
// Directed bench for ads_scan_sequencer (NUM_CH=4, RANGE_CODE=8'h06, SCAN_GAP=8).
// A small engine model answers frame requests with hand-picked read data;
// commands and tagged samples are compared against hand-computed values.

module tb_ads_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  ch_mask;
    logic        frame_req;
    logic [15:0] frame_cmd;
    logic        frame_ack;
    logic        frame_done;
    logic [15:0] frame_rdata;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [15:0] smp_data;
    logic        cfg_done;
    logic        busy;
`ifdef ADS_SCAN_TIMESTAMP_EN
    logic [31:0] smp_ts;
    logic [31:0] lastTs;
    int          lastDoneCyc;
    int          doneCyc;
    bit          haveTs;
`endif

    int passCount;
    int checkCount;
    int cyc;

    ads_scan_sequencer #(
        .NUM_CH    (4),
        .RANGE_CODE(8'h06),
        .SCAN_GAP  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ch_mask    (ch_mask),
        .frame_req  (frame_req),
        .frame_cmd  (frame_cmd),
        .frame_ack  (frame_ack),
        .frame_done (frame_done),
        .frame_rdata(frame_rdata),
        .smp_valid  (smp_valid),
        .smp_ch     (smp_ch),
        .smp_data   (smp_data),
        .cfg_done   (cfg_done),
        .busy       (busy)
`ifdef ADS_SCAN_TIMESTAMP_EN
        ,
        .smp_ts     (smp_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Engine model: wait for a request, optionally hold off the ack, then
    // finish the frame and report whatever sample appears one cycle later.
    task automatic applyStimulus(input logic [15:0] rdata, input int ackDelay, input bit dropRun,
                                 output logic [15:0] cmd, output logic gotSmp,
                                 output logic [2:0] sCh, output logic [15:0] sData);
        int  waitCnt;
        bit  stable;
        cmd    = 16'h0000;
        gotSmp = 1'b0;
        sCh    = '0;
        sData  = '0;
        waitCnt = 0;
        while (frame_req !== 1'b1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (frame_req !== 1'b1) begin
            checkOutput("req_timeout", {31'd0, frame_req}, 32'd1);
            return;
        end
        cmd    = frame_cmd;
        stable = 1'b1;
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            if (frame_req !== 1'b1 || frame_cmd !== cmd) stable = 1'b0;
        end
        if (ackDelay > 0) checkOutput("req_hold", {31'd0, stable}, 32'd1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checkOutput("req_drop", {31'd0, frame_req}, 32'd0);
        if (dropRun) run = 1'b0;
        repeat (3) @(negedge clk);
        frame_rdata = rdata;
        frame_done  = 1'b1;
`ifdef ADS_SCAN_TIMESTAMP_EN
        doneCyc = cyc;
`endif
        @(negedge clk);
        frame_done = 1'b0;
        gotSmp = smp_valid;
        sCh    = smp_ch;
        sData  = smp_data;
`ifdef ADS_SCAN_TIMESTAMP_EN
        if (smp_valid === 1'b1) begin
            if (haveTs) checkOutput("ts_delta", smp_ts - lastTs, 32'(doneCyc - lastDoneCyc));
            lastTs      = smp_ts;
            lastDoneCyc = doneCyc;
            haveTs      = 1'b1;
        end
`endif
    endtask

    logic [15:0] cmd;
    logic        gotSmp;
    logic [2:0]  sCh;
    logic [15:0] sData;
    bit          sawReq;

    logic [15:0] cfgCmds [4] = '{16'h0B06, 16'h0D06, 16'h0F06, 16'h1106};

    initial begin
        cyc         = 0;
        passCount   = 0;
        checkCount  = 0;
        rst         = 1'b1;
        run         = 1'b0;
        ch_mask     = 8'h00;
        frame_ack   = 1'b0;
        frame_done  = 1'b0;
        frame_rdata = 16'h0000;
`ifdef ADS_SCAN_TIMESTAMP_EN
        haveTs      = 1'b0;
        lastTs      = '0;
        lastDoneCyc = 0;
        doneCyc     = 0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_req",  {31'd0, frame_req}, 32'd0);
        checkOutput("rst_cmd",  {16'd0, frame_cmd}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_cfg",  {31'd0, cfg_done}, 32'd0);
        checkOutput("rst_smp",  {31'd0, smp_valid}, 32'd0);
        rst = 1'b0;

        // T1: configuration then full scan of channels 0..3
        $display("[TB] T1 configure and scan mask 0F");
        run     = 1'b1;
        ch_mask = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'hFFFF, 0, 1'b0, cmd, gotSmp, sCh, sData);
            checkOutput($sformatf("cfg_cmd%0d", i), {16'd0, cmd}, {16'd0, cfgCmds[i]});
        end
        checkOutput("cfg_done", {31'd0, cfg_done}, 32'd1);
        applyStimulus(16'hAAAA, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t1_cmd0",  {16'd0, cmd}, 32'hC000);
        checkOutput("t1_prime", {31'd0, gotSmp}, 32'd0);
        applyStimulus(16'h1234, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t1_cmd1", {16'd0, cmd}, 32'hC400);
        checkOutput("t1_v1",   {31'd0, gotSmp}, 32'd1);
        checkOutput("t1_ch1",  {29'd0, sCh}, 32'd0);
        checkOutput("t1_d1",   {16'd0, sData}, 32'h1234);
        @(negedge clk);
        checkOutput("t1_pulse", {31'd0, smp_valid}, 32'd0);
        checkOutput("t1_hold",  {16'd0, smp_data}, 32'h1234);
        applyStimulus(16'h2222, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t1_cmd2", {16'd0, cmd}, 32'hC800);
        checkOutput("t1_ch2",  {29'd0, sCh}, 32'd1);
        applyStimulus(16'h3333, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t1_cmd3", {16'd0, cmd}, 32'hCC00);
        checkOutput("t1_ch3",  {29'd0, sCh}, 32'd2);
        applyStimulus(16'h4444, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t1_cmd4", {16'd0, cmd}, 32'hC000);
        checkOutput("t1_ch4",  {29'd0, sCh}, 32'd3);
        checkOutput("t1_d4",   {16'd0, sData}, 32'h4444);

        // T2: sparse mask, then mask cleared mid-scan
        $display("[TB] T2 mask 05 then 00");
        ch_mask = 8'h05;
        applyStimulus(16'h5555, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t2_cmd0", {16'd0, cmd}, 32'hC800);
        checkOutput("t2_ch0",  {29'd0, sCh}, 32'd0);
        applyStimulus(16'h6666, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t2_cmd1", {16'd0, cmd}, 32'hC000);
        checkOutput("t2_ch1",  {29'd0, sCh}, 32'd2);
        applyStimulus(16'h7777, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t2_cmd2", {16'd0, cmd}, 32'hC800);
        checkOutput("t2_ch2",  {29'd0, sCh}, 32'd0);
        checkOutput("t2_d2",   {16'd0, sData}, 32'h7777);
        ch_mask = 8'h00;
        sawReq  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_req === 1'b1) sawReq = 1'b1;
        end
        checkOutput("t2_noreq", {31'd0, sawReq}, 32'd0);
        checkOutput("t2_busy",  {31'd0, busy}, 32'd1);
        // Stray handshake pulses outside a request must be ignored
        frame_ack  = 1'b1;
        frame_done = 1'b1;
        @(negedge clk);
        frame_ack  = 1'b0;
        frame_done = 1'b0;
        checkOutput("t2_stray_req", {31'd0, frame_req}, 32'd0);
        checkOutput("t2_stray_smp", {31'd0, smp_valid}, 32'd0);

        // T3: delayed ack, request must hold steady
        $display("[TB] T3 delayed ack");
        ch_mask = 8'h0F;
        applyStimulus(16'h8888, 10, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t3_cmd", {16'd0, cmd}, 32'hCC00);
        checkOutput("t3_ch",  {29'd0, sCh}, 32'd2);
        checkOutput("t3_d",   {16'd0, sData}, 32'h8888);

        // T4: run dropped while a frame is outstanding
        $display("[TB] T4 stop and restart");
        applyStimulus(16'h9999, 0, 1'b1, cmd, gotSmp, sCh, sData);
        checkOutput("t4_cmd", {16'd0, cmd}, 32'hC000);
        checkOutput("t4_v",   {31'd0, gotSmp}, 32'd1);
        checkOutput("t4_ch",  {29'd0, sCh}, 32'd3);
        checkOutput("t4_d",   {16'd0, sData}, 32'h9999);
        sawReq = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_req === 1'b1) sawReq = 1'b1;
        end
        checkOutput("t4_noreq", {31'd0, sawReq}, 32'd0);
        checkOutput("t4_busy",  {31'd0, busy}, 32'd0);
        checkOutput("t4_cfg",   {31'd0, cfg_done}, 32'd0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'hFFFF, 0, 1'b0, cmd, gotSmp, sCh, sData);
            checkOutput($sformatf("t4_cfg_cmd%0d", i), {16'd0, cmd}, {16'd0, cfgCmds[i]});
        end
        applyStimulus(16'hBEEF, 0, 1'b0, cmd, gotSmp, sCh, sData);
        checkOutput("t4_rcmd",  {16'd0, cmd}, 32'hC000);
        checkOutput("t4_prime", {31'd0, gotSmp}, 32'd0);

        // T5: reset while a scan frame is outstanding
        $display("[TB] T5 reset mid-frame");
        begin
            int waitCnt;
            waitCnt = 0;
            while (frame_req !== 1'b1 && waitCnt < 200) begin
                @(negedge clk);
                waitCnt++;
            end
            checkOutput("t5_req", {31'd0, frame_req}, 32'd1);
            checkOutput("t5_cmd", {16'd0, frame_cmd}, 32'hC400);
        end
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_req",  {31'd0, frame_req}, 32'd0);
        checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_rst_cfg",  {31'd0, cfg_done}, 32'd0);
        checkOutput("t5_rst_smp",  {31'd0, smp_valid}, 32'd0);
        rst = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
